// File: rtl/led_matrix_pixel_unpacker.sv
// Byte-stream to pixel unpacker feeding the LED matrix core: R,G,B triplets become one
// truncated pixel each, and the stream is held off between frames until the core's image_sync.
module led_matrix_pixel_unpacker #(
    parameter int PANEL_ROWS      = 4,
    parameter int PANEL_COLS      = 4,
    parameter int COLOR_DEPTH     = 4,
    parameter int WAIT_IMAGE_SYNC = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        byte_valid,
    input  logic                        byte_sof,
    input  logic [7:0]                  byte_data,
    output logic                        byte_ready,
    input  logic                        image_sync,
    output logic                        pix_valid,
    output logic                        pix_sync,
    output logic [2:0][COLOR_DEPTH-1:0] pix_rgb,
    output logic                        err_frame
);

    localparam int NUM_PIX = PANEL_ROWS * PANEL_COLS;
    localparam int CNT_W   = $clog2(NUM_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_R,
        GET_G,
        GET_B,
        WAIT_SYNC
    } state_t;

    state_t                 state, state_next;
    logic [COLOR_DEPTH-1:0] r_q, g_q;
    logic [CNT_W-1:0]       pix_cnt;
    logic                   sync_pending;

    logic accept;
    logic latch_r, latch_g, emit, restart, exit_sync;
    logic last_pix;

    // Only the top COLOR_DEPTH bits of each byte are kept; the rest are intentionally dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^byte_data;

    // Ready depends on state (and reset) only, never on byte_valid.
    assign byte_ready = rst_n && (state != WAIT_SYNC);
    assign accept     = byte_valid && byte_ready;
    assign last_pix   = (pix_cnt == LAST_PIX);

    // NOTE: state register uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        latch_r    = 1'b0;
        latch_g    = 1'b0;
        emit       = 1'b0;
        restart    = 1'b0;
        exit_sync  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && byte_sof) begin
                    latch_r    = 1'b1;
                    state_next = GET_G;
                end
            end
            GET_R, GET_G, GET_B: begin
                if (accept && byte_sof) begin
                    // Early SOF: abandon the current frame and treat this byte as a fresh R.
                    restart    = 1'b1;
                    latch_r    = 1'b1;
                    state_next = GET_G;
                end else if (accept) begin
                    case (state)
                        GET_R: begin
                            latch_r    = 1'b1;
                            state_next = GET_G;
                        end
                        GET_G: begin
                            latch_g    = 1'b1;
                            state_next = GET_B;
                        end
                        default: begin
                            emit = 1'b1;
                            if (!last_pix)                 state_next = GET_R;
                            else if (WAIT_IMAGE_SYNC != 0) state_next = WAIT_SYNC;
                            else                           state_next = IDLE;
                        end
                    endcase
                end
            end
            WAIT_SYNC: begin
                if (sync_pending || image_sync) begin
                    exit_sync  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q          <= '0;
            g_q          <= '0;
            pix_cnt      <= '0;
            sync_pending <= 1'b0;
            pix_valid    <= 1'b0;
            pix_sync     <= 1'b0;
            pix_rgb      <= '0;
            err_frame    <= 1'b0;
        end else begin
            pix_valid <= emit;
            err_frame <= restart;
            if (latch_r) r_q <= byte_data[7 -: COLOR_DEPTH];
            if (latch_g) g_q <= byte_data[7 -: COLOR_DEPTH];
            if (emit) begin
                pix_sync <= (pix_cnt == '0);
                pix_rgb  <= {r_q, g_q, byte_data[7 -: COLOR_DEPTH]};
            end
            if (restart)   pix_cnt <= '0;
            else if (emit) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
            // A sync seen mid-frame is remembered so the next frame is released without waiting.
            if (WAIT_IMAGE_SYNC != 0) begin
                if (exit_sync)                              sync_pending <= 1'b0;
                else if (image_sync && state != WAIT_SYNC) sync_pending <= 1'b1;
            end
        end
    end

endmodule
